// File: rtl/voltmeter_pkg.sv
// Shared types and constants for the dual-slope voltmeter front end.
package voltmeter_pkg;

  localparam int RESULT_W = 16;
  localparam logic [RESULT_W-1:0] OVERRANGE_CODE = 16'hFFFF;

  // Default phase lengths in clk cycles and comparator synchroniser depth
  localparam int T_AZ_DEFAULT        = 1000;
  localparam int T_INT_DEFAULT       = 10000;
  localparam int T_DEINT_MAX_DEFAULT = 20000;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // Conversion sequencer states
  typedef enum logic [3:0] {
    ST_IDLE,
    ST_AZ_ARM,
    ST_AZ,
    ST_INT_ARM,
    ST_INT,
    ST_DEINT_ARM,
    ST_DEINT,
    ST_GAP,
    ST_DONE
  } state_e;

  // The counter raises done when its count equals the limit, and it starts
  // from zero, so a phase of N cycles needs a limit of N-1.
  function automatic logic [RESULT_W-1:0] phase_limit(input int cycles);
    return RESULT_W'(cycles - 1);
  endfunction

  localparam logic [RESULT_W-1:0] AZ_LIMIT_DEFAULT    = phase_limit(T_AZ_DEFAULT);
  localparam logic [RESULT_W-1:0] INT_LIMIT_DEFAULT   = phase_limit(T_INT_DEFAULT);
  localparam logic [RESULT_W-1:0] DEINT_LIMIT_DEFAULT = phase_limit(T_DEINT_MAX_DEFAULT);

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser for a single asynchronous input bit.
module sync_ff #(
  parameter int STAGES = 2  // must be at least 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_reg;

  // Shift the raw input through the chain; the last stage is the safe copy
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_reg[STAGES-1];

endmodule

// File: rtl/dual_slope_ctrl.sv
// Dual-slope conversion sequencer: auto-zero, fixed integrate, reference
// de-integrate, with break-before-make gaps and a latched result.
module dual_slope_ctrl
  import voltmeter_pkg::*;
#(
  parameter int T_AZ        = T_AZ_DEFAULT,
  parameter int T_INT       = T_INT_DEFAULT,
  parameter int T_DEINT_MAX = T_DEINT_MAX_DEFAULT,
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                start_i,
  input  logic                abort_i,
  input  logic                cmp_i,
  input  logic                cnt_busy_i,
  input  logic                cnt_done_i,
  input  logic [RESULT_W-1:0] cnt_count_i,
  output logic                cnt_en_o,
  output logic                cnt_clear_o,
  output logic [RESULT_W-1:0] cnt_limit_o,
  output logic                sw_az_o,
  output logic                sw_in_o,
  output logic                sw_ref_o,
  output logic                ref_neg_o,
  output logic                busy_o,
  output logic [RESULT_W-1:0] result_o,
  output logic                polarity_o,
  output logic                overrange_o,
  output logic                result_valid_o
);

  localparam logic [RESULT_W-1:0] AZ_LIMIT     = phase_limit(T_AZ);
  localparam logic [RESULT_W-1:0] INT_LIMIT    = phase_limit(T_INT);
  localparam logic [RESULT_W-1:0] DEINT_LIMIT  = phase_limit(T_DEINT_MAX);
  localparam logic [RESULT_W-1:0] SYNC_LATENCY = RESULT_W'(SYNC_STAGES);

  state_e              state_reg, state_next;
  logic                after_int_reg, after_int_next;
  logic                ref_neg_reg, ref_neg_next;
  logic [RESULT_W-1:0] result_reg, result_next;
  logic                polarity_reg, polarity_next;
  logic                overrange_reg, overrange_next;
  logic                cnt_en_reg, cnt_en_next;
  logic                cnt_clear_reg, cnt_clear_next;
  logic [RESULT_W-1:0] cnt_limit_reg, cnt_limit_next;
  logic                sw_az_reg, sw_az_next;
  logic                sw_in_reg, sw_in_next;
  logic                sw_ref_reg, sw_ref_next;
  logic                busy_reg, busy_next;
  logic                valid_reg, valid_next;
  logic                cmp_sync;
  logic                trip;
  logic                busy_unused;

  // Phase exits key off done alone, so the counter's busy flag is informational
  assign busy_unused = cnt_busy_i;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_cmp_sync (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .d_i    (cmp_i),
    .q_o    (cmp_sync)
  );

  // Integrator has crossed zero once the comparator disagrees with the
  // polarity chosen for the discharge
  assign trip = (state_reg == ST_DEINT) && (cmp_sync != ref_neg_reg);

  // Next-state, polarity latch and result capture
  always_comb begin
    state_next     = state_reg;
    after_int_next = after_int_reg;
    ref_neg_next   = ref_neg_reg;
    result_next    = result_reg;
    polarity_next  = polarity_reg;
    overrange_next = overrange_reg;

    if (abort_i && (state_reg != ST_IDLE)) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_i && !abort_i) begin
            state_next = ST_AZ_ARM;
          end
        end
        ST_AZ_ARM:    state_next = ST_AZ;
        ST_AZ: begin
          if (cnt_done_i) begin
            state_next     = ST_GAP;
            after_int_next = 1'b0;
          end
        end
        ST_INT_ARM:   state_next = ST_INT;
        ST_INT: begin
          if (cnt_done_i) begin
            state_next     = ST_GAP;
            after_int_next = 1'b1;
            // Positive integrator needs the negative reference to discharge
            ref_neg_next   = cmp_sync;
          end
        end
        ST_GAP:       state_next = after_int_reg ? ST_DEINT_ARM : ST_INT_ARM;
        ST_DEINT_ARM: state_next = ST_DEINT;
        ST_DEINT: begin
          if (trip) begin
            // Count has run on while the crossing went through the synchroniser
            state_next     = ST_DONE;
            result_next    = (cnt_count_i >= SYNC_LATENCY) ? (cnt_count_i - SYNC_LATENCY)
                                                           : '0;
            polarity_next  = ref_neg_reg;
            overrange_next = 1'b0;
          end else if (cnt_done_i) begin
            state_next     = ST_DONE;
            result_next    = OVERRANGE_CODE;
            polarity_next  = ref_neg_reg;
            overrange_next = 1'b1;
          end
        end
        ST_DONE:      state_next = ST_IDLE;
        default:      state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode from the upcoming state so every output is a flop
  always_comb begin
    cnt_en_next    = 1'b0;
    cnt_clear_next = 1'b1;
    cnt_limit_next = '0;
    sw_az_next     = 1'b0;
    sw_in_next     = 1'b0;
    sw_ref_next    = 1'b0;
    busy_next      = (state_next != ST_IDLE);
    valid_next     = (state_next == ST_DONE);

    case (state_next)
      ST_AZ_ARM, ST_AZ: begin
        cnt_clear_next = 1'b0;
        cnt_en_next    = (state_next == ST_AZ);
        cnt_limit_next = AZ_LIMIT;
        sw_az_next     = 1'b1;
      end
      ST_INT_ARM, ST_INT: begin
        cnt_clear_next = 1'b0;
        cnt_en_next    = (state_next == ST_INT);
        cnt_limit_next = INT_LIMIT;
        sw_in_next     = 1'b1;
      end
      ST_DEINT_ARM, ST_DEINT: begin
        cnt_clear_next = 1'b0;
        cnt_en_next    = (state_next == ST_DEINT);
        cnt_limit_next = DEINT_LIMIT;
        sw_ref_next    = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sequencer state register
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_reg     <= ST_IDLE;
      after_int_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      after_int_reg <= after_int_next;
    end
  end

  // Registered outputs and held conversion result
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_en_reg    <= 1'b0;
      cnt_clear_reg <= 1'b1;
      cnt_limit_reg <= '0;
      sw_az_reg     <= 1'b0;
      sw_in_reg     <= 1'b0;
      sw_ref_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      valid_reg     <= 1'b0;
      ref_neg_reg   <= 1'b0;
      result_reg    <= '0;
      polarity_reg  <= 1'b0;
      overrange_reg <= 1'b0;
    end else begin
      cnt_en_reg    <= cnt_en_next;
      cnt_clear_reg <= cnt_clear_next;
      cnt_limit_reg <= cnt_limit_next;
      sw_az_reg     <= sw_az_next;
      sw_in_reg     <= sw_in_next;
      sw_ref_reg    <= sw_ref_next;
      busy_reg      <= busy_next;
      valid_reg     <= valid_next;
      ref_neg_reg   <= ref_neg_next;
      result_reg    <= result_next;
      polarity_reg  <= polarity_next;
      overrange_reg <= overrange_next;
    end
  end

  assign cnt_en_o       = cnt_en_reg;
  assign cnt_clear_o    = cnt_clear_reg;
  assign cnt_limit_o    = cnt_limit_reg;
  assign sw_az_o        = sw_az_reg;
  assign sw_in_o        = sw_in_reg;
  assign sw_ref_o       = sw_ref_reg;
  assign ref_neg_o      = ref_neg_reg;
  assign busy_o         = busy_reg;
  assign result_o       = result_reg;
  assign polarity_o     = polarity_reg;
  assign overrange_o    = overrange_reg;
  assign result_valid_o = valid_reg;

endmodule

// File: tb/tb_dual_slope_ctrl.sv
// Bench for dual_slope_ctrl: external counter, timeline model, per-cycle compare.
module tb_dual_slope_ctrl;

  localparam int TAZ  = 4;
  localparam int TINT = 8;
  localparam int TDM  = 16;
  localparam int NS   = 2;
  // Cycle offsets after the start edge: AZ_ARM at 1, AZ for TAZ cycles, gap,
  // INT_ARM, INT for TINT cycles, gap, DEINT_ARM, then de-integrate from D0.
  localparam int INT_END = TAZ + TINT + 3;
  localparam int D0      = TAZ + TINT + 6;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic        cmp = 1'b0;
  logic        cnt_busy, cnt_done;
  logic [15:0] cnt_count;
  logic        cnt_en_o, cnt_clear_o, sw_az_o, sw_in_o, sw_ref_o, ref_neg_o;
  logic        busy_o, polarity_o, overrange_o, result_valid_o;
  logic [15:0] cnt_limit_o, result_o;

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;

  always #5 clk = ~clk;

  dual_slope_ctrl #(
    .T_AZ(TAZ), .T_INT(TINT), .T_DEINT_MAX(TDM), .SYNC_STAGES(NS)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .cmp_i(cmp),
    .cnt_busy_i(cnt_busy), .cnt_done_i(cnt_done), .cnt_count_i(cnt_count),
    .cnt_en_o(cnt_en_o), .cnt_clear_o(cnt_clear_o), .cnt_limit_o(cnt_limit_o),
    .sw_az_o(sw_az_o), .sw_in_o(sw_in_o), .sw_ref_o(sw_ref_o), .ref_neg_o(ref_neg_o),
    .busy_o(busy_o), .result_o(result_o), .polarity_o(polarity_o),
    .overrange_o(overrange_o), .result_valid_o(result_valid_o)
  );

  // Phase counter: en low arms it at zero, en high counts up, done at the limit
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_count <= 16'd0; cnt_busy <= 1'b0; cnt_done <= 1'b0;
    end else if (cnt_clear_o) begin
      cnt_count <= 16'd0; cnt_busy <= 1'b0; cnt_done <= 1'b0;
    end else if (!cnt_en_o) begin
      cnt_count <= 16'd0; cnt_busy <= 1'b1; cnt_done <= 1'b0;
    end else if (cnt_busy) begin
      cnt_count <= cnt_count + 16'd1;
      if (cnt_count + 16'd1 == cnt_limit_o) begin
        cnt_done <= 1'b1; cnt_busy <= 1'b0;
      end
    end
  end

  // Conversion model: m_off is the cycle offset in the current conversion,
  // -1 while idle and -2 in the result cycle.
  int              m_off = -1;
  logic [15:0]     m_result = 16'd0;
  logic            m_pol = 1'b0, m_ovr = 1'b0, m_refneg = 1'b0;
  logic [NS-1:0]   m_cs = '0;

  function automatic logic [15:0] trip_code(input int c);
    return (c > NS) ? 16'(c - NS) : 16'd0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_off <= -1; m_result <= 16'd0; m_pol <= 1'b0; m_ovr <= 1'b0;
      m_refneg <= 1'b0; m_cs <= '0;
    end else begin
      m_cs <= {m_cs[NS-2:0], cmp};
      if (m_off == -1) begin
        if (start && !abort) m_off <= 1;
      end else if (abort) begin
        m_off <= -1;
      end else if (m_off == -2) begin
        m_off <= -1;
      end else if (m_off >= D0 && m_cs[NS-1] != m_refneg) begin
        m_result <= trip_code(m_off - D0); m_pol <= m_refneg; m_ovr <= 1'b0; m_off <= -2;
      end else if (m_off >= D0 && (m_off - D0) == TDM - 1) begin
        m_result <= 16'hFFFF; m_pol <= m_refneg; m_ovr <= 1'b1; m_off <= -2;
      end else begin
        if (m_off == INT_END) m_refneg <= m_cs[NS-1];
        m_off <= m_off + 1;
      end
    end
  end

  function automatic logic [2:0] exp_sw(input int off);
    if (off >= 1 && off <= TAZ + 1) return 3'b100;
    if (off >= TAZ + 3 && off <= INT_END) return 3'b010;
    if (off >= TAZ + TINT + 5) return 3'b001;
    return 3'b000;
  endfunction

  function automatic logic exp_en(input int off);
    return (off >= 2 && off <= TAZ + 1) || (off >= TAZ + 4 && off <= INT_END) || (off >= D0);
  endfunction

  function automatic logic [15:0] exp_limit(input logic [2:0] sw);
    case (sw)
      3'b100:  return 16'(TAZ - 1);
      3'b010:  return 16'(TINT - 1);
      3'b001:  return 16'(TDM - 1);
      default: return 16'd0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic [2:0] sw_now, sw_exp, prev_sw = 3'b000, last_nz = 3'b000;
  assign sw_now = {sw_az_o, sw_in_o, sw_ref_o};
  assign sw_exp = exp_sw(m_off);

  // Per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    chk("sw_set", 32'(sw_now), 32'(sw_exp));
    chk("sw_onehot", 32'($countones(sw_now) <= 1), 32'd1);
    if (sw_now != 3'b000 && last_nz != 3'b000 && sw_now != last_nz)
      chk("gap_between_phases", 32'(prev_sw), 32'd0);
    chk("cnt_en", 32'(cnt_en_o), 32'(exp_en(m_off)));
    if (sw_exp != 3'b000) begin
      chk("cnt_clear_phase", 32'(cnt_clear_o), 32'd0);
      chk("cnt_limit", 32'(cnt_limit_o), 32'(exp_limit(sw_exp)));
    end else if (m_off < 0) begin
      chk("cnt_clear_idle", 32'(cnt_clear_o), 32'd1);
    end
    chk("busy", 32'(busy_o), 32'(m_off != -1));
    chk("result_valid", 32'(result_valid_o), 32'(m_off == -2));
    chk("result", 32'(result_o), 32'(m_result));
    chk("overrange", 32'(overrange_o), 32'(m_ovr));
    chk("polarity", 32'(polarity_o), 32'(m_pol));
    chk("ref_neg", 32'(ref_neg_o), 32'(m_refneg));
    if (result_valid_o) n_valid <= n_valid + 1;
    prev_sw <= sw_now;
    if (sw_now != 3'b000) last_nz <= sw_now;
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    int v0;
    logic last_done;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    tick;

    // 1: reset in the middle of de-integrate
    cmp = 1'b1; start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!(sw_ref_o && cnt_en_o) && n < 200) begin tick; n++; end
    chk("t1_reached_deint", 32'(sw_ref_o && cnt_en_o), 32'd1);
    tick; tick;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("t1_busy", 32'(busy_o), 32'd0);
    chk("t1_switches", 32'({sw_az_o, sw_in_o, sw_ref_o}), 32'd0);
    chk("t1_cnt_clear", 32'(cnt_clear_o), 32'd1);
    chk("t1_cnt_en", 32'(cnt_en_o), 32'd0);
    chk("t1_cnt_limit", 32'(cnt_limit_o), 32'd0);
    chk("t1_ref_neg", 32'(ref_neg_o), 32'd0);
    chk("t1_result", 32'(result_o), 32'd0);
    chk("t1_flags", 32'({polarity_o, overrange_o, result_valid_o}), 32'd0);
    $display("reset mid-deint: busy=%0b sw=%03b ref_neg=%0b", busy_o,
             {sw_az_o, sw_in_o, sw_ref_o}, ref_neg_o);
    #1 rst_n = 1'b1;
    tick;

    // 2: positive input, comparator crossing seen at count 5
    cmp = 1'b1; v0 = n_valid; start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!(sw_ref_o && cnt_en_o && cnt_count == 16'd3) && n < 200) begin tick; n++; end
    chk("t2_reached_count3", 32'(sw_ref_o && cnt_en_o && cnt_count == 16'd3), 32'd1);
    cmp = 1'b0;
    n = 0;
    while (!result_valid_o && n < 200) begin tick; n++; end
    chk("t2_valid_seen", 32'(result_valid_o), 32'd1);
    $display("conv 2: result=%0h pol=%0b ovr=%0b ref_neg=%0b", result_o, polarity_o,
             overrange_o, ref_neg_o);
    chk("t2_result", 32'(result_o), 32'd3);
    chk("t2_polarity", 32'(polarity_o), 32'd1);
    chk("t2_overrange", 32'(overrange_o), 32'd0);
    chk("t2_ref_neg", 32'(ref_neg_o), 32'd1);
    tick;
    chk("t2_valid_single", 32'(result_valid_o), 32'd0);
    tick;
    chk("t2_valid_count", 32'(n_valid - v0), 32'd1);

    // 3: comparator never crosses, de-integrate times out
    cmp = 1'b1; v0 = n_valid; tick; start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!result_valid_o && n < 200) begin tick; n++; end
    chk("t3_valid_seen", 32'(result_valid_o), 32'd1);
    $display("conv 3: result=%0h pol=%0b ovr=%0b", result_o, polarity_o, overrange_o);
    chk("t3_result", 32'(result_o), 32'h0000_FFFF);
    chk("t3_overrange", 32'(overrange_o), 32'd1);
    tick; tick;
    chk("t3_valid_count", 32'(n_valid - v0), 32'd1);

    // 4: negative input, crossing lands on the same cycle as counter done
    cmp = 1'b0; v0 = n_valid; tick; start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!(sw_ref_o && cnt_en_o && cnt_count == 16'd13) && n < 200) begin tick; n++; end
    chk("t4_reached_count13", 32'(sw_ref_o && cnt_en_o && cnt_count == 16'd13), 32'd1);
    cmp = 1'b1;
    n = 0; last_done = 1'b0;
    while (!result_valid_o && n < 200) begin last_done = cnt_done; tick; n++; end
    chk("t4_valid_seen", 32'(result_valid_o), 32'd1);
    $display("conv 4: result=%0h pol=%0b ovr=%0b done_at_trip=%0b", result_o, polarity_o,
             overrange_o, last_done);
    chk("t4_done_coincident", 32'(last_done), 32'd1);
    chk("t4_result", 32'(result_o), 32'd13);
    chk("t4_overrange", 32'(overrange_o), 32'd0);
    chk("t4_polarity", 32'(polarity_o), 32'd0);
    tick; tick;
    chk("t4_valid_count", 32'(n_valid - v0), 32'd1);

    // 5: abort during integrate
    cmp = 1'b1; v0 = n_valid; tick; start = 1'b1; tick; start = 1'b0;
    n = 0;
    while (!(sw_in_o && cnt_en_o) && n < 200) begin tick; n++; end
    chk("t5_reached_int", 32'(sw_in_o && cnt_en_o), 32'd1);
    tick;
    abort = 1'b1; tick; abort = 1'b0;
    $display("abort: busy=%0b sw=%03b result=%0h", busy_o, {sw_az_o, sw_in_o, sw_ref_o},
             result_o);
    chk("t5_busy", 32'(busy_o), 32'd0);
    chk("t5_switches", 32'({sw_az_o, sw_in_o, sw_ref_o}), 32'd0);
    chk("t5_cnt_clear", 32'(cnt_clear_o), 32'd1);
    chk("t5_result_held", 32'(result_o), 32'd13);
    repeat (40) tick;
    chk("t5_no_valid", 32'(n_valid - v0), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
